mem_wait_unit: RTL and testbench



---
 rtl/mem_wait_if.sv | 24 ++
 rtl/mem_wait_unit.sv | 133 +++++++++++++
 tb/tb_mem_wait_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wait_if.sv
// Memory request/response bundle between the microprogrammed controller (master)
// and mem_wait_unit (slave).
interface mem_wait_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wait_;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output mem_rd, mem_wr, addr, wdata,
    input  wait_, rdata, busy
  );

  modport slave (
    input  mem_rd, mem_wr, addr, wdata,
    output wait_, rdata, busy
  );
endinterface

// File: rtl/mem_wait_unit.sv
// Fixed-latency synchronous word memory that stalls the controller through wait_.
// Define MEM_STATS_EN to add completed-read/write counters (rd_cnt, wr_cnt).
module mem_wait_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  mem_wait_if.slave   bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LatM1 = 4'(LATENCY - 1);
  localparam bit         Lat1  = (LATENCY == 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;

  logic              req;
  logic              acc_idle;
  logic              acc_fire;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign req       = bus.mem_rd | bus.mem_wr;
  assign bus.wait_ = req & (state_q != StDone);
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  // With LATENCY == 1 the access uses the live inputs on the accepting edge;
  // otherwise it uses the operands latched when the request was accepted.
  always_comb begin
    acc_idle  = 1'b0;
    acc_fire  = 1'b0;
    acc_wr    = op_wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (Lat1 && (state_q == StIdle) && req) begin
      acc_idle = 1'b1;
    end
    if (acc_idle) begin
      acc_wr    = bus.mem_wr;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end
    acc_fire = !reset && (acc_idle || ((state_q == StBusy) && (cnt_q == 4'd1)));
  end

  always_ff @(posedge clk) begin
    if (acc_fire && acc_wr) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (acc_fire && !acc_wr) begin
        rdata_q <= mem[acc_addr];
      end
      case (state_q)
        StIdle: begin
          if (req) begin
            op_wr_q <= bus.mem_wr;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= LatM1;
            state_q <= Lat1 ? StDone : StBusy;
            busy_q  <= !Lat1;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (acc_fire) begin
      if (acc_wr) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wait_unit.sv
// Self-checking bench for mem_wait_unit: LATENCY=3 instance against a timeline model,
// plus a LATENCY=1 instance for the alternating wait_ pattern.
module tb_mem_wait_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_wait_if #(.ADDR_W(8), .DATA_W(16)) bus3 ();
  mem_wait_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt3, wr_cnt3, rd_cnt1, wr_cnt1;
`endif

  mem_wait_unit #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus3)
`ifdef MEM_STATS_EN
    ,
    .rd_cnt (rd_cnt3),
    .wr_cnt (wr_cnt3)
`endif
  );

  mem_wait_unit #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus1)
`ifdef MEM_STATS_EN
    ,
    .rd_cnt (rd_cnt1),
    .wr_cnt (wr_cnt1)
`endif
  );

  localparam int L = 3;

  int errors = 0;
  int checks = 0;

  // Reference model: an access accepted in cycle s completes on the edge ending
  // cycle s+L-1, the unit shows "done" during cycle s+L and is free from s+L+1.
  logic [15:0] mem_m [256];
  logic [15:0] m_rdata = 16'h0;
  bit          has_acc = 1'b0;
  int          cyc = 0;
  int          s_cyc = 0;
  int          comp = 0;
  bit          m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  int          m_rdcnt = 0;
  int          m_wrcnt = 0;

  logic [17:0] exp3, obs3, obs1;
  logic [15:0] obs_rdc, obs_wrc;

  task automatic set3(input bit rd, input bit wr, input logic [7:0] a, input logic [15:0] d);
    bus3.mem_rd = rd;
    bus3.mem_wr = wr;
    bus3.addr   = a;
    bus3.wdata  = d;
  endtask

  task automatic set1(input bit rd, input bit wr, input logic [7:0] a, input logic [15:0] d);
    bus1.mem_rd = rd;
    bus1.mem_wr = wr;
    bus1.addr   = a;
    bus1.wdata  = d;
  endtask

  // One clock: predict, sample at negedge, then advance the model past the edge.
  task automatic tick();
    bit rq;
    bit idle;
    rq   = bus3.mem_rd | bus3.mem_wr;
    exp3 = {rq && !(has_acc && cyc == comp), has_acc && cyc > s_cyc && cyc < comp, m_rdata};
    @(negedge clk);
    obs3 = {bus3.wait_, bus3.busy, bus3.rdata};
    obs1 = {bus1.wait_, bus1.busy, bus1.rdata};
`ifdef MEM_STATS_EN
    obs_rdc = rd_cnt3;
    obs_wrc = wr_cnt3;
`else
    obs_rdc = 16'h0;
    obs_wrc = 16'h0;
`endif
    @(posedge clk);
    idle = !has_acc || cyc > comp;
    if (reset) begin
      has_acc = 1'b0;
      m_rdata = 16'h0;
      m_rdcnt = 0;
      m_wrcnt = 0;
    end else begin
      if (idle && rq) begin
        has_acc = 1'b1;
        s_cyc   = cyc;
        comp    = cyc + L;
        m_wr    = bus3.mem_wr;
        m_addr  = bus3.addr;
        m_wdata = bus3.wdata;
      end
      if (has_acc && cyc + 1 == comp) begin
        if (m_wr) begin
          mem_m[m_addr] = m_wdata;
          m_wrcnt++;
        end else begin
          m_rdata = mem_m[m_addr];
          m_rdcnt++;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    set3(0, 0, 8'h0, 16'h0);
    set1(0, 0, 8'h0, 16'h0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs3 !== 18'h0 || obs3 !== exp3) begin
        errors++;
        $display("FAIL reset_idle k=%0d got=%h expected=%h", k, obs3, exp3);
      end
      checks++;
      if (obs1 !== 18'h0) begin
        errors++;
        $display("FAIL reset_idle_lat1 k=%0d got=%h expected=0", k, obs1);
      end
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) begin
      set3(0, 1, 8'(a), 16'($urandom));
      for (int k = 0; k <= L; k++) begin
        tick();
        checks++;
        if (obs3 !== exp3) begin
          errors++;
          $display("FAIL fill a=%0d k=%0d got=%h expected=%h", a, k, obs3, exp3);
        end
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
  endtask

  task automatic test_write_read();
    set3(0, 1, 8'h12, 16'hBEEF);
    for (int k = 0; k <= L; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || obs3[17] !== (k < L)) begin
        errors++;
        $display("FAIL write_beef k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(1, 0, 8'h12, 16'h0);
    for (int k = 0; k <= L; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || (k == L && obs3 !== {2'b00, 16'hBEEF})) begin
        errors++;
        $display("FAIL read_beef k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
  endtask

  task automatic test_both();
    set3(1, 1, 8'h05, 16'h1234);
    for (int k = 0; k <= L; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || obs3[15:0] !== 16'hBEEF) begin
        errors++;
        $display("FAIL rd_wr_both k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(1, 0, 8'h05, 16'h0);
    for (int k = 0; k <= L; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || (k == L && obs3[15:0] !== 16'h1234)) begin
        errors++;
        $display("FAIL rd_after_both k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
  endtask

  task automatic test_addr_change();
    set3(0, 1, 8'h30, 16'h0F0F);
    tick();
    for (int k = 1; k <= L; k++) begin
      set3(0, 1, 8'h31 + 8'(k), 16'($urandom));
      tick();
      checks++;
      if (obs3 !== exp3) begin
        errors++;
        $display("FAIL addr_change k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
    set3(1, 0, 8'h30, 16'h0);
    for (int k = 0; k <= L; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || (k == L && obs3[15:0] !== 16'h0F0F)) begin
        errors++;
        $display("FAIL addr_change_rd k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
  endtask

  task automatic test_abort();
    set3(0, 1, 8'h20, 16'h5555);
    for (int k = 0; k <= L; k++) tick();
    set3(0, 0, 8'h0, 16'h0);
    tick();
    set3(0, 1, 8'h20, 16'hAAAA);
    tick();
    set3(0, 0, 8'h0, 16'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || obs3 !== 18'h0) begin
        errors++;
        $display("FAIL abort_idle k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(1, 0, 8'h20, 16'h0);
    for (int k = 0; k <= L; k++) begin
      tick();
      checks++;
      if (obs3 !== exp3 || (k == L && obs3[15:0] !== 16'h5555)) begin
        errors++;
        $display("FAIL abort_rd k=%0d got=%h expected=%h", k, obs3, exp3);
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set3($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           8'($urandom), 16'($urandom));
      tick();
      checks++;
      if (obs3 !== exp3) begin
        errors++;
        $display("FAIL random n=%0d got=%h expected=%h", n, obs3, exp3);
      end
    end
    set3(0, 0, 8'h0, 16'h0);
    for (int k = 0; k <= L; k++) tick();
  endtask

  task automatic test_lat1();
    logic [15:0] v [4];
    logic [15:0] prev;
    for (int j = 0; j < 4; j++) begin
      v[j] = 16'($urandom);
      set1(0, 1, 8'h40 + 8'(j), v[j]);
      tick();
      checks++;
      if (obs1[17:16] !== 2'b10) begin
        errors++;
        $display("FAIL lat1_wr_wait j=%0d got=%b expected=10", j, obs1[17:16]);
      end
      tick();
      checks++;
      if (obs1[17:16] !== 2'b00) begin
        errors++;
        $display("FAIL lat1_wr_done j=%0d got=%b expected=00", j, obs1[17:16]);
      end
    end
    prev = 16'h0;
    for (int j = 0; j < 8; j++) begin
      set1(1, 0, 8'h40 + 8'(j % 4), 16'h0);
      tick();
      checks++;
      if (obs1 !== {2'b10, prev}) begin
        errors++;
        $display("FAIL lat1_rd_wait j=%0d got=%h expected=%h", j, obs1, {2'b10, prev});
      end
      tick();
      prev = v[j % 4];
      checks++;
      if (obs1 !== {2'b00, prev}) begin
        errors++;
        $display("FAIL lat1_rd_done j=%0d got=%h expected=%h", j, obs1, {2'b00, prev});
      end
    end
    set1(0, 0, 8'h0, 16'h0);
    tick();
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j < 2) set3(1, 0, 8'h60 + 8'(j), 16'h0);
      else set3(0, 1, 8'h60 + 8'(j), 16'($urandom));
      for (int k = 0; k <= L; k++) tick();
    end
    set3(0, 0, 8'h0, 16'h0);
    tick();
    checks++;
    if (obs_rdc !== 16'd2 || obs_wrc !== 16'd3 || obs_rdc !== 16'(m_rdcnt)
        || obs_wrc !== 16'(m_wrcnt)) begin
      errors++;
      $display("FAIL stats rd=%0d wr=%0d expected rd=2 wr=3", obs_rdc, obs_wrc);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set3(0, 0, 8'h0, 16'h0);
    set1(0, 0, 8'h0, 16'h0);
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_write_read();
    test_both();
    test_addr_change();
    test_abort();
    test_random();
    test_lat1();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
